fx3_stream_out_capture: RTL and testbench
=========================================

Name: fx3_stream_out_capture

Overview:
- Downstream partner of the FX3 slave-FIFO stream-OUT read controller.
- Watches the controller's active-low SLRD/SLOE strobes and aligns them to the FX3 read latency.
- Captures the 32-bit words the FX3 drives and buffers them in a FWFT FIFO.
- Presents the words on a valid/ready stream to the pixel/DVI side, and also reports almost-full, a word count, an overflow flag and burst completion.

Parameters:
- DATA_W, 32, FX3 bus and stream width.
- RD_LATENCY, 2, clock edges from SLRD/SLOE sampled low to the data word being valid on fx3_data. Legal range 1..4.
- FIFO_DEPTH, 16, buffer entries. Must be a power of 2, ≥ 8.
- AFULL_MARGIN, 4, free-slot threshold for fifo_afull. Must be ≥ RD_LATENCY+2.

Ports:
- clk_100  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- slrd_n  in  1  SLRD strobe from the stream-out controller, active low.
- sloe_n  in  1  SLOE strobe from the stream-out controller, active low.
- fx3_data  in  DATA_W  FX3 data bus.
- m_data  out  DATA_W  head-of-FIFO word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts the word.
- fifo_afull  out  1  buffer near full; upstream must stop starting reads.
- word_count  out  32  accepted words since reset or clear; wraps.
- overflow  out  1  sticky; a captured word was dropped.
- burst_done  out  1  one-cycle pulse when a read burst has fully drained into the FIFO.
- burst_len  out  16  words accepted in the last completed burst; saturates at 0xFFFF.
- clear_stats  in  1  synchronous clear of word_count and overflow.

Behaviour:
- Reset (async, active-high): everything below is cleared and any in-flight words are discarded.
  - rd_pipe = 0, FIFO empty, FSM = IDLE.
  - m_valid = 0, m_data = 0, fifo_afull = 0, word_count = 0, overflow = 0, burst_done = 0, burst_len = 0.
- Read-alignment pipeline:
  - rd_pipe[0] <= ~slrd_n & ~sloe_n; rd_pipe[k] <= rd_pipe[k-1].
  - wr_en = rd_pipe[RD_LATENCY-1].
  - On an edge with wr_en = 1, fx3_data is the word written.
  - A strobe pair sampled low at edge E produces a write at edge E+RD_LATENCY.
- FIFO (FWFT):
  - m_valid = (count != 0); m_data = mem[rd_ptr]. m_data is held stable while m_valid & ~m_ready.
  - pop = m_valid & m_ready.
  - push = wr_en & ((count < FIFO_DEPTH) | pop). A write into a full FIFO is accepted only when a pop occurs on the same edge.
  - wr_en & ~push drops the word and sets overflow.
  - Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
  - First write into an empty FIFO: m_valid = 1 in the cycle after the write edge.
- fifo_afull = (count >= FIFO_DEPTH - AFULL_MARGIN), decoded from the registered count. It is combinational from the count flops with no extra delay.
- word_count:
  - +1 per push, wraps at 2^32.
  - clear_stats with a simultaneous push gives word_count = 1.
- overflow:
  - Set on a drop, cleared by clear_stats.
  - Drop and clear on the same edge leave overflow = 1 (set wins).
- Burst FSM:
  - IDLE → ACTIVE on the first push. Clear the burst counter to 1 on that edge.
  - ACTIVE: burst counter +1 per push, saturating at 0xFFFF. ACTIVE → DRAIN when sloe_n = 1 and rd_pipe[0] = 0.
  - DRAIN: pushes still count. DRAIN → IDLE when rd_pipe is all zero. On that transition burst_done = 1 for exactly one cycle and burst_len <= burst counter.
  - DRAIN → ACTIVE if ~slrd_n & ~sloe_n is seen again before rd_pipe empties. The burst continues and no burst_done is issued.
  - A burst whose writes are all dropped never leaves IDLE and produces no burst_done.
- Reset mid-burst: no burst_done is produced; the FIFO contents are lost.

Decomposition:
- Package fx3_pkg holds:
  - FX3_DATA_W = 32.
  - Default FX3 read latency = 2.
  - Burst FSM state enum {IDLE, ACTIVE, DRAIN}, 2-bit encoding.
- One sub-module, fx3_rx_fifo: parameterised FWFT synchronous FIFO with push/pop/count/full/empty, async active-high reset.
- Alignment pipeline, counters and FSM live in the top.

Test Plan:
- Single read:
  - Stimulus: slrd_n = sloe_n = 0 for one cycle sampled at edge 10; fx3_data = 0xDEADBEEF at edge 12; m_ready = 1.
  - Required: write at edge 12; m_valid high for one cycle after; m_data = 0xDEADBEEF; word_count = 1; burst_done pulses once with burst_len = 1.
- Streaming burst:
  - Stimulus: 8 consecutive strobes with fx3_data = 0,1,…,7 aligned to the writes; m_ready = 1.
  - Required: m_data emits 0..7 in order; word_count = 8; burst_len = 8; overflow = 0.
- Backpressure and afull:
  - Stimulus: m_ready = 0, 13 words pushed, defaults.
  - Required: fifo_afull rises when count reaches 12; count = 13; m_data holds the first word.
- Overflow:
  - Stimulus: m_ready = 0, 18 strobes.
  - Required: 16 words stored, 2 dropped; overflow = 1; word_count = 16.
  - Then clear_stats: word_count = 0, overflow = 0.
- Full with simultaneous pop:
  - Stimulus: FIFO full; m_ready = 1 and wr_en on the same edge.
  - Required: push accepted, count stays 16, overflow stays 0.
- Reset mid-burst:
  - Stimulus: assert reset for one cycle after 3 of 6 writes.
  - Required: m_valid = 0 immediately (async); no burst_done; word_count = 0; the next burst after release starts cleanly with burst_len counted from 1.

Source files
------------

// File: rtl/fx3_pkg.sv
// Shared constants and burst-tracking state encoding for the FX3 stream-OUT capture path.
package fx3_pkg;
  localparam int FX3_DATA_W     = 32;
  localparam int FX3_RD_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } burst_state_e;
endpackage

// File: rtl/fx3_rx_fifo.sv
// First-word-fall-through synchronous FIFO; head word is visible while not empty.
module fx3_rx_fifo
  import fx3_pkg::*;
#(
  parameter int DATA_W = FX3_DATA_W,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_push,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  // Gated so the output reads zero out of reset instead of stale storage.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fx3_stream_out_capture.sv
// Aligns FX3 SLRD/SLOE to the read latency, buffers captured words, tracks stats and bursts.
//   state  | meaning
//   IDLE   | no burst in progress
//   ACTIVE | words being pushed, controller still strobing
//   DRAIN  | strobes stopped, waiting for in-flight reads to land
module fx3_stream_out_capture
  import fx3_pkg::*;
#(
  parameter int DATA_W       = FX3_DATA_W,
  parameter int RD_LATENCY   = FX3_RD_LATENCY,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              slrd_n,
  input  logic              sloe_n,
  input  logic [DATA_W-1:0] fx3_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              fifo_afull,
  output logic [31:0]       word_count,
  output logic              overflow,
  output logic              burst_done,
  output logic [15:0]       burst_len,
  input  logic              clear_stats
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [RD_LATENCY-1:0] r_rd_pipe;
  logic [31:0]           r_word_count;
  logic                  r_overflow;
  logic                  r_burst_done;
  logic [15:0]           r_burst_len;
  logic [15:0]           r_burst_cnt;
  burst_state_e          r_state;
  burst_state_e          w_state_nxt;
  logic                  w_done;
  logic                  w_strobe;
  logic                  w_wr_en;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;

  assign w_strobe = ~slrd_n & ~sloe_n;
  assign w_wr_en  = r_rd_pipe[RD_LATENCY-1];
  assign w_pop    = m_valid & m_ready;
  // A full FIFO still accepts the word when the head leaves on the same edge.
  assign w_push   = w_wr_en & (~w_full | w_pop);
  assign w_drop   = w_wr_en & ~w_push;

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      r_rd_pipe <= '0;
    end else begin
      r_rd_pipe[0] <= w_strobe;
      for (int k = 1; k < RD_LATENCY; k++) r_rd_pipe[k] <= r_rd_pipe[k-1];
    end
  end

  fx3_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_100),
    .rst     (reset),
    .i_wdata (fx3_data),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .o_rdata (m_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign m_valid    = ~w_empty;
  assign fifo_afull = (w_count >= CNT_W'(FIFO_DEPTH - AFULL_MARGIN));

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      r_word_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (clear_stats)  r_word_count <= w_push ? 32'd1 : 32'd0;
      else if (w_push)  r_word_count <= r_word_count + 32'd1;
      if (w_drop)           r_overflow <= 1'b1;
      else if (clear_stats) r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      IDLE:   if (w_push) w_state_nxt = ACTIVE;
      ACTIVE: if (sloe_n && !r_rd_pipe[0]) w_state_nxt = DRAIN;
      DRAIN: begin
        // A fresh strobe pair resumes the same burst rather than closing it.
        if (w_strobe) begin
          w_state_nxt = ACTIVE;
        end else if (r_rd_pipe == '0) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_burst_cnt  <= '0;
      r_burst_done <= 1'b0;
      r_burst_len  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_burst_done <= w_done;
      if (r_state == IDLE) begin
        if (w_push) r_burst_cnt <= 16'd1;
      end else if (w_push && r_burst_cnt != 16'hFFFF) begin
        r_burst_cnt <= r_burst_cnt + 16'd1;
      end
      if (w_done) r_burst_len <= r_burst_cnt;
    end
  end

  assign word_count = r_word_count;
  assign overflow   = r_overflow;
  assign burst_done = r_burst_done;
  assign burst_len  = r_burst_len;

endmodule

// File: tb/tb_fx3_stream_out_capture.sv
// Bench for fx3_stream_out_capture: table-driven bursts plus directed corner sequences.
module tb_fx3_stream_out_capture;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic        slrd_n;
  logic        sloe_n;
  logic [31:0] fx3_data;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        fifo_afull;
  logic [31:0] word_count;
  logic        overflow;
  logic        burst_done;
  logic [15:0] burst_len;
  logic        clear_stats;

  fx3_stream_out_capture dut (
    .clk_100     (clk_100),
    .reset       (reset),
    .slrd_n      (slrd_n),
    .sloe_n      (sloe_n),
    .fx3_data    (fx3_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .fifo_afull  (fifo_afull),
    .word_count  (word_count),
    .overflow    (overflow),
    .burst_done  (burst_done),
    .burst_len   (burst_len),
    .clear_stats (clear_stats)
  );

  always #5 clk_100 = ~clk_100;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          bd_cnt  = 0;
  int          vcnt    = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic [31:0] h0 = '0;
  logic [31:0] h1 = '0;

  typedef struct {
    int          n;
    logic [31:0] base;
    logic        always_rdy;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drives the inputs for the next edge; fx3_data follows the strobe by two cycles.
  task automatic step(input logic strb, input logic [31:0] d, input logic rdy,
                      input logic clr, input logic store);
    @(posedge clk_100);
    #1;
    fx3_data    = h1;
    h1          = h0;
    h0          = d;
    slrd_n      = ~strb;
    sloe_n      = ~strb;
    m_ready     = rdy;
    clear_stats = clr;
    if (strb && store) exp_q.push_back(d);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic clear_pulse(input logic rdy);
    step(1'b0, 32'h0, rdy, 1'b1, 1'b0);
    step(1'b0, 32'h0, rdy, 1'b0, 1'b0);
  endtask

  always @(negedge clk_100) begin
    if (burst_done) bd_cnt++;
    if (m_valid) vcnt++;
    if (m_valid && m_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no word", m_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (m_data !== exp_w) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h, expected 0x%0h", m_data, exp_w);
        end
      end
    end
  end

  initial begin
    logic seen;
    vecs[0] = '{n: 1,  base: 32'hDEADBEEF, always_rdy: 1'b1};
    vecs[1] = '{n: 8,  base: 32'h0,        always_rdy: 1'b1};
    vecs[2] = '{n: 5,  base: 32'h0000_1000, always_rdy: 1'b0};
    vecs[3] = '{n: 16, base: 32'hA000_0000, always_rdy: 1'b1};

    reset = 1'b1; slrd_n = 1'b1; sloe_n = 1'b1; fx3_data = '0;
    m_ready = 1'b0; clear_stats = 1'b0;
    #2;
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_afull", {31'b0, fifo_afull}, 32'd0);
    check("rst_word_count", word_count, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    check("rst_burst_done", {31'b0, burst_done}, 32'd0);
    check("rst_burst_len", {16'b0, burst_len}, 32'd0);
    repeat (2) @(posedge clk_100);
    #1 reset = 1'b0;
    idle(2, 1'b1);

    // Table-driven bursts, consumer draining.
    foreach (vecs[v]) begin
      clear_pulse(1'b1);
      check("tbl_clear_wc", word_count, 32'd0);
      bd_cnt = 0;
      vcnt   = 0;
      for (int i = 0; i < vecs[v].n; i++)
        step(1'b1, vecs[v].base + 32'(i),
             vecs[v].always_rdy ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      idle(12, 1'b1);
      check("tbl_word_count", word_count, 32'(vecs[v].n));
      check("tbl_burst_len", {16'b0, burst_len}, 32'(vecs[v].n));
      check("tbl_burst_done_cnt", 32'(bd_cnt), 32'd1);
      check("tbl_overflow", {31'b0, overflow}, 32'd0);
      check("tbl_q_empty", 32'(exp_q.size()), 32'd0);
      check("tbl_m_valid_end", {31'b0, m_valid}, 32'd0);
      if (vecs[v].always_rdy) check("tbl_valid_cycles", 32'(vcnt), 32'(vecs[v].n));
    end

    // Backpressure: afull must first appear exactly when the 12th word lands.
    clear_pulse(1'b0);
    seen = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 13) step(1'b1, 32'h0000_B000 + 32'(i), 1'b0, 1'b0, 1'b1);
      else        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      if (fifo_afull && !seen) begin
        seen = 1'b1;
        check("afull_rise_count", word_count, 32'd12);
      end
    end
    check("afull_seen", {31'b0, seen}, 32'd1);
    check("bp_word_count", word_count, 32'd13);
    check("bp_m_valid", {31'b0, m_valid}, 32'd1);
    check("bp_m_data_head", m_data, 32'h0000_B000);
    check("bp_afull_held", {31'b0, fifo_afull}, 32'd1);
    idle(20, 1'b1);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_afull_low", {31'b0, fifo_afull}, 32'd0);

    // Overflow: 18 reads into a stalled 16-entry buffer.
    clear_pulse(1'b0);
    for (int i = 0; i < 18; i++) step(1'b1, 32'h0000_C000 + 32'(i), 1'b0, 1'b0, 1'b1 ? (i < 16) : 1'b0);
    idle(4, 1'b0);
    check("ovf_word_count", word_count, 32'd16);
    check("ovf_flag", {31'b0, overflow}, 32'd1);
    check("ovf_head", m_data, 32'h0000_C000);

    // Drop and clear on the same edge: set wins.
    step(1'b1, 32'h0000_D000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("dropclr_overflow", {31'b0, overflow}, 32'd1);
    check("dropclr_wc", word_count, 32'd0);

    clear_pulse(1'b0);
    check("clr_overflow", {31'b0, overflow}, 32'd0);
    check("clr_wc", word_count, 32'd0);

    // Full FIFO with a pop on the write edge.
    step(1'b1, 32'h0000_E000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("fullpop_wc", word_count, 32'd1);
    check("fullpop_overflow", {31'b0, overflow}, 32'd0);
    check("fullpop_afull", {31'b0, fifo_afull}, 32'd1);
    // Still full afterwards, so the next read is dropped.
    step(1'b1, 32'h0000_E001, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("stillfull_overflow", {31'b0, overflow}, 32'd1);
    clear_pulse(1'b1);
    idle(24, 1'b1);
    check("full_drained", 32'(exp_q.size()), 32'd0);
    check("full_drained_valid", {31'b0, m_valid}, 32'd0);

    // clear_stats on the same edge as a push.
    step(1'b1, 32'h0000_0077, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("clrpush_wc", word_count, 32'd1);
    idle(6, 1'b1);

    // Reset after 3 of 6 writes.
    clear_pulse(1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 32'h0000_F000 + 32'(i), 1'b0, 1'b0, 1'b1);
    check("prerst_wc", word_count, 32'd3);
    check("prerst_valid", {31'b0, m_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'b0, m_valid}, 32'd0);
    check("midrst_wc", word_count, 32'd0);
    check("midrst_burst_len", {16'b0, burst_len}, 32'd0);
    exp_q.delete();
    h0 = '0;
    h1 = '0;
    bd_cnt = 0;
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    idle(6, 1'b1);
    check("postrst_no_done", 32'(bd_cnt), 32'd0);
    check("postrst_valid", {31'b0, m_valid}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_5000 + 32'(i), 1'b1, 1'b0, 1'b1);
    idle(10, 1'b1);
    check("newburst_len", {16'b0, burst_len}, 32'd4);
    check("newburst_done_cnt", 32'(bd_cnt), 32'd1);
    check("newburst_wc", word_count, 32'd4);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
